axi_stream_fifo: RTL and testbench
==================================

// Module: axi_stream_fifo
// PURPOSE
//  Parametrised AXI4-Stream buffer (FIFO) between a stream producer (s_axis) and consumer (m_axis).
//  Generalises the fixed 16-bit stream bus to configurable data/user width and buffer depth.
//  Decouples backpressure between pipeline stages (e.g. ADC capture -> FFT -> readout).
//  Reports fill level and optionally releases data only once whole packets are buffered.
// PARAMETERS
//  DATA_WIDTH  16  tdata width in bits; multiple of 8, >= 8
//  USER_WIDTH  1   tuser width in bits, >= 1
//  DEPTH       16  entries; power of two, >= 2
//  Derived: KW = DATA_WIDTH/8 (tstrb/tkeep width); CW = $clog2(DEPTH)+1 (count width)
// PORTS
//  aclk            in   1           clock; all logic on rising edge
//  aresetn         in   1           asynchronous active-low reset
//  s_axis_tdata    in   DATA_WIDTH  input beat data
//  s_axis_tstrb    in   KW          input byte strobes
//  s_axis_tkeep    in   KW          input byte keeps
//  s_axis_tlast    in   1           input end of packet
//  s_axis_tuser    in   USER_WIDTH  input sideband
//  s_axis_tvalid   in   1           input beat valid
//  s_axis_tready   out  1           FIFO can accept a beat
//  m_axis_tdata    out  DATA_WIDTH  output beat data
//  m_axis_tstrb    out  KW          output byte strobes
//  m_axis_tkeep    out  KW          output byte keeps
//  m_axis_tlast    out  1           output end of packet
//  m_axis_tuser    out  USER_WIDTH  output sideband
//  m_axis_tvalid   out  1           output beat valid
//  m_axis_tready   in   1           consumer accepts beat
//  fill_level      out  CW          stored beats, 0..DEPTH
// BEHAVIOUR
//  - Reset (aresetn low, async): pointers=0, fill_level=0, s_axis_tready=0 while asserted, then 1 on
//    first edge after release; m_axis_tvalid=0; m_axis_tdata/tstrb/tkeep/tuser=0, tlast=0.
//    Reset mid-operation discards all stored beats; no partial beat survives.
//  - Push = s_axis_tvalid & s_axis_tready; pop = m_axis_tvalid & m_axis_tready; one each max per cycle.
//  - Storage: DEPTH x (DATA_WIDTH+2*KW+1+USER_WIDTH) array; wr_ptr/rd_ptr CW bits, wrap modulo DEPTH
//    using MSB as lap bit; full = ptrs equal except MSB; empty = ptrs equal.
//  - s_axis_tready is registered: high iff not full after this edge's update; a pop in the cycle
//    the FIFO is full re-raises tready next cycle (no same-cycle combinational path from m to s).
//  - Output is first-word-fall-through from a registered output stage: a beat pushed into an empty
//    FIFO at edge N drives m_axis_tvalid=1 in the cycle after edge N (latency 1, no bypass).
//  - While m_axis_tvalid=1 and m_axis_tready=0 all m_axis_* hold stable (AXI rule).
//  - fill_level counts beats in array + output stage; +1 push, -1 pop, unchanged on simultaneous
//    push+pop; never exceeds DEPTH, never underflows.
//  - Simultaneous push+pop at full: impossible (tready=0); at empty: push stored, nothing popped.
//  - Beats leave in arrival order; tdata/tstrb/tkeep/tlast/tuser travel together unmodified.
// CONFIGURATION
//  AXIS_FIFO_PACKET_MODE_EN defined: m_axis_tvalid asserts only when >=1 complete packet (tlast
//    beat) is stored or FIFO is full (deadlock release). Packet counter (CW bits): +1 on push with
//    tlast, -1 on pop with tlast, unchanged if both same cycle; reset to 0. Once a packet starts
//    draining, tvalid is not withdrawn mid-beat.
//  Not defined: counter absent; m_axis_tvalid asserts whenever FIFO non-empty (plain FIFO).
// TESTING
//  1. DEPTH=16, m_tready=1, push 1 beat 0xA5A5 -> m_tvalid=1 one cycle later with 0xA5A5, fill 1->0.
//  2. m_tready=0, push 16 beats -> fill_level=16, s_tready=0 cycle after 16th push; 17th held off.
//  3. Full, then m_tready=1 and s_tvalid=1 continuous -> s_tready back next cycle, order 0..N intact,
//     fill_level steady at 15/16, no beat lost or duplicated.
//  4. Stall m_tready=0 for 5 cycles with tvalid=1 -> m_axis_* unchanged throughout stall.
//  5. aresetn low with fill=9 mid-stream -> m_tvalid=0, fill=0 immediately; after release first
//     output equals first beat pushed after reset.
//  6. PACKET_MODE_EN: push 3 beats no tlast -> m_tvalid=0; push 4th with tlast -> all 4 emitted;
//     push 16 beats without tlast -> full releases tvalid=1 (no deadlock).

Source files
------------

// File: rtl/axi_stream_fifo.sv
// AXI4-Stream FIFO with a registered first-word-fall-through output stage.
// Define AXIS_FIFO_PACKET_MODE_EN to hold m_axis_tvalid low until a whole packet
// (or a full buffer) is stored; leave it undefined for a plain FIFO.
module axi_stream_fifo #(
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned USER_WIDTH = 1,
    parameter int unsigned DEPTH      = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [DATA_WIDTH-1:0]     s_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tstrb,
    input  logic [DATA_WIDTH/8-1:0]   s_axis_tkeep,
    input  logic                      s_axis_tlast,
    input  logic [USER_WIDTH-1:0]     s_axis_tuser,
    input  logic                      s_axis_tvalid,
    output logic                      s_axis_tready,
    output logic [DATA_WIDTH-1:0]     m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tstrb,
    output logic [DATA_WIDTH/8-1:0]   m_axis_tkeep,
    output logic                      m_axis_tlast,
    output logic [USER_WIDTH-1:0]     m_axis_tuser,
    output logic                      m_axis_tvalid,
    input  logic                      m_axis_tready,
    output logic [$clog2(DEPTH):0]    fill_level
);

    localparam int unsigned KW = DATA_WIDTH / 8;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned BW = DATA_WIDTH + 2 * KW + 1 + USER_WIDTH;

    // Array holds every stored beat except the one sitting in the output stage.
    logic [BW-1:0] mem [DEPTH];

    logic [CW-1:0] wr_ptr;
    logic [CW-1:0] rd_ptr;
    logic [CW-1:0] wr_ptr_n;
    logic [CW-1:0] rd_ptr_n;
    logic [CW-1:0] fill_n;
    logic [BW-1:0] in_beat;
    logic [BW-1:0] out_beat;
    logic [BW-1:0] out_beat_n;
    logic          out_present;
    logic          out_present_n;
    logic          tvalid_n;
    logic          tready_n;
    logic          push;
    logic          pop;
    logic          arr_empty;
    logic          out_free;
    logic          arr_wr;

    assign in_beat = {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast, s_axis_tuser};
    assign {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast, m_axis_tuser} = out_beat;

    // Handshakes, array/output-stage movement and occupancy for the next edge.
    always_comb begin
        push          = s_axis_tvalid & s_axis_tready;
        pop           = m_axis_tvalid & m_axis_tready;
        arr_empty     = (wr_ptr == rd_ptr);
        out_free      = ~out_present | pop;
        wr_ptr_n      = wr_ptr;
        rd_ptr_n      = rd_ptr;
        out_beat_n    = out_beat;
        out_present_n = out_present;
        arr_wr        = 1'b0;

        if (out_free) begin
            if (!arr_empty) begin
                out_beat_n    = mem[rd_ptr[AW-1:0]];
                rd_ptr_n      = rd_ptr + CW'(1);
                out_present_n = 1'b1;
            end else if (push) begin
                // Empty FIFO: the incoming beat goes straight into the output register.
                out_beat_n    = in_beat;
                out_present_n = 1'b1;
            end else begin
                out_present_n = 1'b0;
            end
        end

        if (push && !(out_free && arr_empty)) begin
            arr_wr   = 1'b1;
            wr_ptr_n = wr_ptr + CW'(1);
        end

        fill_n   = fill_level + CW'(push) - CW'(pop);
        tready_n = (fill_n != CW'(DEPTH));
    end

`ifdef AXIS_FIFO_PACKET_MODE_EN
    logic [CW-1:0] pkt_cnt;
    logic [CW-1:0] pkt_cnt_n;
    logic          draining;
    logic          draining_n;

    // Release gating: complete packet stored, buffer full, or a packet already partly sent.
    always_comb begin
        pkt_cnt_n  = pkt_cnt;
        draining_n = draining;
        if ((push && s_axis_tlast) && !(pop && m_axis_tlast)) begin
            pkt_cnt_n = pkt_cnt + CW'(1);
        end else if (!(push && s_axis_tlast) && (pop && m_axis_tlast)) begin
            pkt_cnt_n = pkt_cnt - CW'(1);
        end
        if (pop) begin
            draining_n = ~m_axis_tlast;
        end
        tvalid_n = out_present_n &
                   ((pkt_cnt_n != CW'(0)) | (fill_n == CW'(DEPTH)) | draining_n);
    end

    // Packet counter and mid-packet drain flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt  <= '0;
            draining <= 1'b0;
        end else begin
            pkt_cnt  <= pkt_cnt_n;
            draining <= draining_n;
        end
    end
`else
    // Plain FIFO: present whenever the output stage holds a beat.
    always_comb begin
        tvalid_n = out_present_n;
    end
`endif

    // Control state and registered outputs.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            fill_level    <= '0;
            out_present   <= 1'b0;
            out_beat      <= '0;
            m_axis_tvalid <= 1'b0;
            s_axis_tready <= 1'b0;
        end else begin
            wr_ptr        <= wr_ptr_n;
            rd_ptr        <= rd_ptr_n;
            fill_level    <= fill_n;
            out_present   <= out_present_n;
            out_beat      <= out_beat_n;
            m_axis_tvalid <= tvalid_n;
            s_axis_tready <= tready_n;
        end
    end

    // Beat storage write port.
    always_ff @(posedge aclk) begin
        if (arr_wr) begin
            mem[wr_ptr[AW-1:0]] <= in_beat;
        end
    end

endmodule

// File: tb/tb_axi_stream_fifo.sv
// Scoreboard bench for axi_stream_fifo (DATA_WIDTH=16, USER_WIDTH=1, DEPTH=16).
module tb_axi_stream_fifo;

    localparam int unsigned DW = 16;
    localparam int unsigned UW = 1;
    localparam int unsigned DP = 16;
    localparam int unsigned BW = DW + 2 * (DW / 8) + 1 + UW;

    logic          aclk = 1'b0;
    logic          aresetn;
    logic [15:0]   s_axis_tdata;
    logic [1:0]    s_axis_tstrb;
    logic [1:0]    s_axis_tkeep;
    logic          s_axis_tlast;
    logic [0:0]    s_axis_tuser;
    logic          s_axis_tvalid;
    logic          s_axis_tready;
    logic [15:0]   m_axis_tdata;
    logic [1:0]    m_axis_tstrb;
    logic [1:0]    m_axis_tkeep;
    logic          m_axis_tlast;
    logic [0:0]    m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic [4:0]    fill_level;

    int checks = 0;
    int errors = 0;
    logic [BW-1:0] exp_q [$];
    logic [BW-1:0] held;
    bit            stall_prev = 1'b0;

    axi_stream_fifo #(.DATA_WIDTH(DW), .USER_WIDTH(UW), .DEPTH(DP)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .s_axis_tdata(s_axis_tdata), .s_axis_tstrb(s_axis_tstrb), .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tstrb(m_axis_tstrb), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .fill_level(fill_level)
    );

    always #5 aclk = ~aclk;

    // Monitor: score popped beats in order and check output stability under stall.
    always @(negedge aclk) begin
        logic [BW-1:0] cur;
        logic [BW-1:0] exp;
        cur = {m_axis_tdata, m_axis_tstrb, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
        if (!aresetn) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                checks++;
                if (!m_axis_tvalid || cur != held) begin
                    errors++;
                    $display("FAIL stall_hold: got valid=%0b beat=0x%0h expected valid=1 beat=0x%0h",
                             m_axis_tvalid, cur, held);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_beat: got 0x%0h expected no beat", cur);
                end else begin
                    exp = exp_q.pop_front();
                    if (cur != exp) begin
                        errors++;
                        $display("FAIL beat_order: got 0x%0h expected 0x%0h", cur, exp);
                    end
                end
            end
            if (s_axis_tvalid && s_axis_tready) begin
                exp_q.push_back({s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast, s_axis_tuser});
            end
            stall_prev = m_axis_tvalid && !m_axis_tready;
            held       = cur;
        end
    end

    // Watchdog so the bench always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge aclk);
        #1;
    endtask

    // Directed beat i: data 0x1000+i, strb=i[1:0], keep=~i[1:0], tlast every 4th, user=i[2].
    function automatic logic [BW-1:0] beat_of(input int i);
        logic [15:0] d;
        logic [1:0]  s;
        logic        l;
        logic        u;
        d = 16'h1000 + 16'(i);
        s = 2'(i);
        l = ((i % 4) == 3);
        u = 1'((i >> 2) & 1);
        return {d, s, ~s, l, u};
    endfunction

    // Drive one beat and return #1 after the edge that accepted it.
    task automatic send(input logic [BW-1:0] b);
        bit done;
        done = 1'b0;
        {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast, s_axis_tuser} = b;
        s_axis_tvalid = 1'b1;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge aclk);
            if (s_axis_tready) begin
                @(posedge aclk);
                #1;
                done = 1'b1;
            end
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL send_timeout: got tready=0 expected tready=1 within 200 cycles");
        end
    endtask

    task automatic wait_fill(input string name, input logic [4:0] target);
        bit done;
        done = (fill_level == target);
        for (int n = 0; n < 200 && !done; n++) begin
            cyc();
            done = (fill_level == target);
        end
        check(name, 32'(fill_level), 32'(target));
    endtask

    initial begin
        aresetn       = 1'b0;
        s_axis_tvalid = 1'b0;
        {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast, s_axis_tuser} = '0;
        m_axis_tready = 1'b0;
        repeat (3) cyc();

        // Reset state
        check("rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("rst_fill",     32'(fill_level),    32'd0);
        check("rst_m_tdata",  32'(m_axis_tdata),  32'd0);
        check("rst_m_tlast",  32'(m_axis_tlast),  32'd0);
        aresetn = 1'b1;
        cyc();
        check("post_rst_s_tready", 32'(s_axis_tready), 32'd1);

        // 1: single beat, latency 1
        m_axis_tready = 1'b1;
        send({16'hA5A5, 2'b11, 2'b11, 1'b1, 1'b0});
        check("t1_m_tvalid", 32'(m_axis_tvalid), 32'd1);
        check("t1_m_tdata",  32'(m_axis_tdata),  32'h0000A5A5);
        check("t1_fill1",    32'(fill_level),    32'd1);
        cyc();
        check("t1_fill0",    32'(fill_level),    32'd0);
        check("t1_m_tvalid0", 32'(m_axis_tvalid), 32'd0);

        // 2: fill to 16 with consumer stalled
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send(beat_of(i));
            if (i == 14) begin
                check("t2_fill15",     32'(fill_level),    32'd15);
                check("t2_s_tready15", 32'(s_axis_tready), 32'd1);
            end
        end
        check("t2_fill16",    32'(fill_level),    32'd16);
        check("t2_s_tready0", 32'(s_axis_tready), 32'd0);
        check("t2_head",      32'(m_axis_tdata),  32'h00001000);
        {s_axis_tdata, s_axis_tstrb, s_axis_tkeep, s_axis_tlast, s_axis_tuser} = beat_of(16);
        s_axis_tvalid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc();
            check("t2_held_fill",  32'(fill_level),    32'd16);
            check("t2_held_ready", 32'(s_axis_tready), 32'd0);
        end

        // 3: drain while streaming; occupancy settles at 15
        m_axis_tready = 1'b1;
        for (int i = 16; i < 28; i++) begin
            send(beat_of(i));
            check("t3_fill_steady", 32'(fill_level), 32'd15);
        end
        wait_fill("t3_drain", 5'd0);
        check("t3_m_tvalid0", 32'(m_axis_tvalid), 32'd0);

        // 4: five-cycle stall holds outputs
        m_axis_tready = 1'b0;
        for (int i = 28; i < 32; i++) send(beat_of(i));
        check("t4_fill", 32'(fill_level), 32'd4);
        check("t4_head", 32'(m_axis_tdata), 32'h0000101C);
        repeat (5) cyc();
        check("t4_head_held", 32'(m_axis_tdata), 32'h0000101C);
        check("t4_valid_held", 32'(m_axis_tvalid), 32'd1);
        m_axis_tready = 1'b1;
        wait_fill("t4_drain", 5'd0);

        // 5: reset mid-stream
        m_axis_tready = 1'b0;
        for (int i = 32; i < 41; i++) send(beat_of(i));
        check("t5_fill9", 32'(fill_level), 32'd9);
        aresetn = 1'b0;
        #1;
        check("t5_rst_m_tvalid", 32'(m_axis_tvalid), 32'd0);
        check("t5_rst_fill",     32'(fill_level),    32'd0);
        check("t5_rst_s_tready", 32'(s_axis_tready), 32'd0);
        check("t5_rst_m_tdata",  32'(m_axis_tdata),  32'd0);
        exp_q.delete();
        repeat (2) cyc();
        aresetn = 1'b1;
        cyc();
        check("t5_s_tready", 32'(s_axis_tready), 32'd1);
        m_axis_tready = 1'b1;
        send({16'hBEEF, 2'b01, 2'b10, 1'b1, 1'b1});
        check("t5_first_valid", 32'(m_axis_tvalid), 32'd1);
        check("t5_first_data",  32'(m_axis_tdata),  32'h0000BEEF);
        wait_fill("t5_drain", 5'd0);

`ifdef AXIS_FIFO_PACKET_MODE_EN
        // 6: packet release and full-buffer deadlock release
        m_axis_tready = 1'b1;
        for (int i = 0; i < 3; i++) send({16'h2000 + 16'(i), 2'b11, 2'b11, 1'b0, 1'b0});
        repeat (3) cyc();
        check("t6_no_pkt_valid", 32'(m_axis_tvalid), 32'd0);
        check("t6_no_pkt_fill",  32'(fill_level),    32'd3);
        send({16'h2003, 2'b11, 2'b11, 1'b1, 1'b0});
        check("t6_pkt_valid", 32'(m_axis_tvalid), 32'd1);
        wait_fill("t6_pkt_drain", 5'd0);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            send({16'h3000 + 16'(i), 2'b11, 2'b11, 1'b0, 1'b0});
            if (i == 14) check("t6_valid15", 32'(m_axis_tvalid), 32'd0);
        end
        check("t6_full_valid", 32'(m_axis_tvalid), 32'd1);
        check("t6_full_fill",  32'(fill_level),    32'd16);
        m_axis_tready = 1'b1;
        wait_fill("t6_full_drain", 5'd0);
`endif

        repeat (3) cyc();
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
